// File: rtl/glue_bus_cycle_ctrl_pkg.sv
// Shared definitions for the 68000 bus-cycle glue: FSM state encodings and bus constants.
package glue_bus_cycle_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SEL  = 3'd1,
    ST_WAIT = 3'd2,
    ST_ACK  = 3'd3,
    ST_BERR = 3'd4,
    ST_DONE = 3'd5
  } state_t;

  localparam logic [2:0] FC_CPU_SPACE = 3'b111;
  localparam int         N_REGIONS    = 8;

  // States in which the selected region's chip select and strobes are driven.
  function automatic logic is_cs_state(input state_t s);
    return (s == ST_SEL) || (s == ST_WAIT) || (s == ST_ACK);
  endfunction

endpackage

// File: rtl/glue_bus_cycle_ctrl_decoder.sv
// 74x138-style 3-to-8 decoder with active-low outputs and three enables.
module decoder_3_to_8
  import glue_bus_cycle_ctrl_pkg::*;
(
  input  logic [2:0]           a,
  input  logic                 e1_n,
  input  logic                 e2_n,
  input  logic                 e3,
  output logic [N_REGIONS-1:0] y_n
);

  always_comb begin
    y_n = '1;
    if (!e1_n && !e2_n && e3) begin
      y_n[a] = 1'b0;
    end
  end

endmodule

// File: rtl/glue_bus_cycle_ctrl.sv
// 68000 bus-cycle controller: region decode, per-region wait states, DTACK_n/BERR_n
// generation with timeout. All CPU-facing outputs come straight from flops.
module glue_bus_cycle_ctrl
  import glue_bus_cycle_ctrl_pkg::*;
#(
  parameter int WAIT_W  = 4,
  parameter int TIMEOUT = 64,
  parameter int TMO_W   = 7
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          as_n,
  input  logic                          rw,
  input  logic [2:0]                    fc,
  input  logic [2:0]                    addr_hi,
  input  logic [N_REGIONS-1:0]          region_en,
  input  logic [N_REGIONS*WAIT_W-1:0]   wait_cfg,
  output logic [N_REGIONS-1:0]          cs_n,
  output logic                          dtack_n,
  output logic                          berr_n,
  output logic                          rd_n,
  output logic                          wr_n
);

  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [WAIT_W-1:0] WCNT_ONE = WAIT_W'(1);

  logic                 as_m, as_s;
  state_t               state, state_nxt;
  logic [2:0]           reg_l, reg_nxt;
  logic                 rw_l, rw_nxt;
  logic [WAIT_W-1:0]    wcnt, wcnt_nxt;
  logic [TMO_W-1:0]     tmo, tmo_nxt;
  logic [WAIT_W-1:0]    wait_cur;
  logic                 tmo_hit;
  logic                 cs_act;
  logic [N_REGIONS-1:0] dec_y_n;

  // as_n is asynchronous to clk; idle-high reset value keeps a fresh cycle from starting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      as_m <= 1'b1;
      as_s <= 1'b1;
    end else begin
      as_m <= as_n;
      as_s <= as_m;
    end
  end

  assign wait_cur = wait_cfg[reg_l*WAIT_W +: WAIT_W];
  assign tmo_hit  = (tmo == TMO_LAST);

  always_comb begin
    state_nxt = state;
    reg_nxt   = reg_l;
    rw_nxt    = rw_l;
    wcnt_nxt  = wcnt;
    tmo_nxt   = tmo;
    case (state)
      ST_IDLE: begin
        if (!as_s) begin
          reg_nxt = addr_hi;
          rw_nxt  = rw;
          tmo_nxt = '0;
          if (fc == FC_CPU_SPACE)      state_nxt = ST_DONE;
          else if (!region_en[addr_hi]) state_nxt = ST_BERR;
          else                          state_nxt = ST_SEL;
        end
      end
      ST_SEL: begin
        tmo_nxt  = tmo + TMO_W'(1);
        wcnt_nxt = wait_cur;
        if (as_s)                 state_nxt = ST_IDLE;
        else if (tmo_hit)         state_nxt = ST_BERR;
        else if (wait_cur == '0)  state_nxt = ST_ACK;
        else                      state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        tmo_nxt  = tmo + TMO_W'(1);
        wcnt_nxt = wcnt - WCNT_ONE;
        if (as_s)                  state_nxt = ST_IDLE;
        else if (tmo_hit)          state_nxt = ST_BERR;
        else if (wcnt == WCNT_ONE) state_nxt = ST_ACK;
      end
      ST_ACK: begin
        // DTACK_n is already low here, so the timer only runs up to its limit and parks.
        if (!tmo_hit) tmo_nxt = tmo + TMO_W'(1);
        if (as_s) state_nxt = ST_IDLE;
      end
      ST_BERR: begin
        if (as_s) state_nxt = ST_IDLE;
      end
      ST_DONE: begin
        if (!tmo_hit) tmo_nxt = tmo + TMO_W'(1);
        if (as_s)         state_nxt = ST_IDLE;
        else if (tmo_hit) state_nxt = ST_BERR;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      reg_l <= '0;
      rw_l  <= 1'b1;
      wcnt  <= '0;
      tmo   <= '0;
    end else begin
      state <= state_nxt;
      reg_l <= reg_nxt;
      rw_l  <= rw_nxt;
      wcnt  <= wcnt_nxt;
      tmo   <= tmo_nxt;
    end
  end

  // Outputs are decoded from the next state so each flop shows the state it enters.
  assign cs_act = is_cs_state(state_nxt);

  decoder_3_to_8 u_dec (
    .a    (reg_nxt),
    .e1_n (~cs_act),
    .e2_n (1'b0),
    .e3   (cs_act),
    .y_n  (dec_y_n)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_n    <= '1;
      dtack_n <= 1'b1;
      berr_n  <= 1'b1;
      rd_n    <= 1'b1;
      wr_n    <= 1'b1;
    end else begin
      cs_n    <= dec_y_n;
      dtack_n <= (state_nxt != ST_ACK);
      berr_n  <= (state_nxt != ST_BERR);
      rd_n    <= !(cs_act && rw_nxt);
      wr_n    <= !(cs_act && !rw_nxt);
    end
  end

endmodule

// File: tb/tb_glue_bus_cycle_ctrl.sv
// Scoreboard bench for glue_bus_cycle_ctrl: stimulus queues expected output changes
// with the cycle they must appear on; a monitor compares every output change.
module tb_glue_bus_cycle_ctrl;

  localparam int WAIT_W = 4;

  logic                clk = 1'b0;
  logic                rst_n = 1'b1;
  logic                as_n = 1'b1;
  logic                rw = 1'b1;
  logic [2:0]          fc = 3'b101;
  logic [2:0]          addr_hi = 3'd0;
  logic [7:0]          region_en = 8'hFF;
  logic [8*WAIT_W-1:0] wait_cfg = '0;
  logic [7:0]          cs_n;
  logic                dtack_n, berr_n, rd_n, wr_n;

  glue_bus_cycle_ctrl #(.WAIT_W(WAIT_W), .TIMEOUT(8), .TMO_W(7)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .as_n      (as_n),
    .rw        (rw),
    .fc        (fc),
    .addr_hi   (addr_hi),
    .region_en (region_en),
    .wait_cfg  (wait_cfg),
    .cs_n      (cs_n),
    .dtack_n   (dtack_n),
    .berr_n    (berr_n),
    .rd_n      (rd_n),
    .wr_n      (wr_n)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // {cs_n, dtack_n, berr_n, rd_n, wr_n}
  logic [11:0] vec;
  assign vec = {cs_n, dtack_n, berr_n, rd_n, wr_n};

  typedef struct {
    int          cyc;
    logic [11:0] vec;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic done = 1'b0;

  task automatic push(input int c, input logic [11:0] v, input string n);
    exp_t e;
    e.cyc = c; e.vec = v; e.name = n;
    exp_q.push_back(e);
  endtask

  task automatic goto(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic start(input logic r, input logic [2:0] f, input logic [2:0] a, output int t);
    rw = r; fc = f; addr_hi = a; as_n = 1'b0;
    t = cyc;
  endtask

  // Monitor: owns all comparison counting.
  initial begin
    logic [11:0] prev, cur;
    exp_t        e;
    prev = 12'hFFF;
    @(negedge clk); #1;
    checks++;
    if (vec !== 12'hFFF) begin
      errors++;
      $display("FAIL reset_state got %h want fff", vec);
    end
    forever begin
      @(negedge clk or negedge rst_n); #1;
      cur = vec;
      checks++;
      if (!cur[3] && !cur[2]) begin
        errors++;
        $display("FAIL dtack_berr_overlap got %h at cycle %0d", cur, cyc);
      end
      checks++;
      if ($countones(~cur[11:4]) > 1) begin
        errors++;
        $display("FAIL cs_multi got cs_n=%h at cycle %0d", cur[11:4], cyc);
      end
      if (cur !== prev) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change got %h at cycle %0d want %h", cur, cyc, prev);
        end else begin
          e = exp_q.pop_front();
          if (cur !== e.vec || cyc != e.cyc) begin
            errors++;
            $display("FAIL %s got %h @%0d want %h @%0d", e.name, cur, cyc, e.vec, e.cyc);
          end
        end
        prev = cur;
      end
      if (done) begin
        while (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          checks++;
          errors++;
          $display("FAIL %s missing got none want %h @%0d", e.name, e.vec, e.cyc);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end
    end
  end

  initial begin
    int t, r;
    wait_cfg[0*WAIT_W +: WAIT_W] = 4'd0;
    wait_cfg[1*WAIT_W +: WAIT_W] = 4'd1;
    wait_cfg[2*WAIT_W +: WAIT_W] = 4'd15;
    wait_cfg[3*WAIT_W +: WAIT_W] = 4'd2;
    wait_cfg[4*WAIT_W +: WAIT_W] = 4'd10;
    wait_cfg[6*WAIT_W +: WAIT_W] = 4'd0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    goto(cyc + 3);

    // Read region 3, 2 waits; wait_cfg change mid-cycle must be ignored.
    start(1'b1, 3'b101, 3'd3, t);
    push(t + 3, 12'hF7D, "t1_sel");
    push(t + 6, 12'hF75, "t1_ack");
    goto(t + 4);
    wait_cfg[3*WAIT_W +: WAIT_W] = 4'd9;
    goto(t + 8);
    as_n = 1'b1; r = cyc;
    push(r + 3, 12'hFFF, "t1_release");
    goto(r + 4);
    wait_cfg[3*WAIT_W +: WAIT_W] = 4'd2;

    // Write region 0, zero waits.
    goto(cyc + 2);
    start(1'b0, 3'b101, 3'd0, t);
    push(t + 3, 12'hFEE, "t2_sel");
    push(t + 4, 12'hFE6, "t2_ack");
    goto(t + 6);
    as_n = 1'b1; r = cyc;
    push(r + 3, 12'hFFF, "t2_release");

    // Unmapped region 5.
    goto(r + 4);
    region_en = 8'hDF;
    start(1'b1, 3'b101, 3'd5, t);
    push(t + 3, 12'hFFB, "t3_berr");
    goto(t + 8);
    as_n = 1'b1; r = cyc;
    push(r + 3, 12'hFFF, "t3_release");
    goto(r + 4);
    region_en = 8'hFF;

    // Region 2 with 15 waits against an 8-clock timeout.
    goto(cyc + 2);
    start(1'b1, 3'b101, 3'd2, t);
    push(t + 3,  12'hFBD, "t4_sel");
    push(t + 11, 12'hFFB, "t4_timeout_berr");
    goto(t + 14);
    as_n = 1'b1; r = cyc;
    push(r + 3, 12'hFFF, "t4_release");

    // Abort during WAIT of a 10-wait write to region 4.
    goto(r + 4);
    start(1'b0, 3'b101, 3'd4, t);
    push(t + 3, 12'hEFE, "t5_sel");
    goto(t + 3);
    as_n = 1'b1; r = cyc;
    push(r + 3, 12'hFFF, "t5_abort");

    // Async reset in the middle of ACK.
    goto(r + 5);
    start(1'b1, 3'b101, 3'd0, t);
    push(t + 3, 12'hFED, "t5b_sel");
    push(t + 4, 12'hFE5, "t5b_ack");
    goto(t + 6);
    @(posedge clk);
    #2;
    push(cyc, 12'hFFF, "t5b_async_reset");
    rst_n = 1'b0;
    as_n  = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    goto(cyc + 3);

    // CPU-space cycle: no chip select, no acknowledge.
    start(1'b1, 3'b111, 3'd2, t);
    goto(t + 4);
    as_n = 1'b1;
    goto(t + 8);
    fc = 3'b101;

    // Back-to-back: region 1 read then region 6 write with one high clock between.
    start(1'b1, 3'b101, 3'd1, t);
    push(t + 3, 12'hFDD, "t6_r1_sel");
    push(t + 5, 12'hFD5, "t6_r1_ack");
    goto(t + 6);
    as_n = 1'b1; r = cyc;
    push(r + 3, 12'hFFF, "t6_r1_release");
    goto(r + 1);
    start(1'b0, 3'b101, 3'd6, t);
    push(t + 3, 12'hBFE, "t6_r6_sel");
    push(t + 4, 12'hBF6, "t6_r6_ack");
    goto(t + 5);
    as_n = 1'b1; r = cyc;
    push(r + 3, 12'hFFF, "t6_r6_release");

    goto(r + 8);
    done = 1'b1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
